// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, master IDs and counter width for the
// two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: both master request/response channels plus the shared
// memory bus. "slave" is the arbiter's view, "master" is the environment's.
interface mem_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_error;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata, mem_error,
    output m0_gnt, m0_ack, m0_rdata, m0_err,
    output m1_gnt, m1_ack, m1_rdata, m1_err,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata, mem_error,
    input  m0_gnt, m0_ack, m0_rdata, m0_err,
    input  m1_gnt, m1_ack, m1_rdata, m1_err,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection between the two masters.
// Build option MEM_ARB_ROUND_ROBIN_EN: under contention grant the master that
// did not win last time; otherwise master 0 has fixed priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic m0_req,
  input  logic m1_req,
  input  logic last_winner,
  output logic valid_c,
  output logic winner_id_c
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Alternate under contention, otherwise take whoever is requesting
  always_comb begin
    valid_c     = m0_req | m1_req;
    winner_id_c = M_CPU;
    if (m0_req && m1_req) begin
      winner_id_c = ~last_winner;
    end else if (m1_req) begin
      winner_id_c = M_AUX;
    end
  end
`else
  // History is kept by the arbiter but selection ignores it
  logic unused_last_winner;
  assign unused_last_winner = last_winner;

  // Master 0 always wins when it is requesting
  always_comb begin
    valid_c     = m0_req | m1_req;
    winner_id_c = M_CPU;
    if (!m0_req && m1_req) begin
      winner_id_c = M_AUX;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between the core (master 0) and an
// auxiliary master (master 1). Each access holds the bus for MEM_LATENCY
// cycles, then returns a one-cycle ack with read data and accumulated error.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (see arb_pick); default is fixed priority to master 0.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_winner;
  logic             err_acc;
  logic             pick_valid;
  logic             pick_winner;

  arb_pick u_pick (
    .m0_req      (bus.m0_req),
    .m1_req      (bus.m1_req),
    .last_winner (last_winner),
    .valid_c     (pick_valid),
    .winner_id_c (pick_winner)
  );

  // Access sequencer: grant, hold the bus for the latency, then acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      owner        <= M_CPU;
      last_winner  <= M_AUX;
      err_acc      <= 1'b0;
      bus.m0_gnt   <= 1'b0;
      bus.m0_ack   <= 1'b0;
      bus.m0_rdata <= DATA_W'(0);
      bus.m0_err   <= 1'b0;
      bus.m1_gnt   <= 1'b0;
      bus.m1_ack   <= 1'b0;
      bus.m1_rdata <= DATA_W'(0);
      bus.m1_err   <= 1'b0;
      bus.mem_addr <= ADDR_W'(0);
      bus.mem_wdata <= DATA_W'(0);
      bus.mem_we   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state       <= ACCESS;
            owner       <= pick_winner;
            last_winner <= pick_winner;
            cnt         <= CNT_W'(MEM_LATENCY);
            err_acc     <= 1'b0;
            if (pick_winner == M_AUX) begin
              bus.mem_addr  <= bus.m1_addr;
              bus.mem_wdata <= bus.m1_wdata;
              bus.mem_we    <= bus.m1_we;
              bus.m1_gnt    <= 1'b1;
            end else begin
              bus.mem_addr  <= bus.m0_addr;
              bus.mem_wdata <= bus.m0_wdata;
              bus.mem_we    <= bus.m0_we;
              bus.m0_gnt    <= 1'b1;
            end
          end
        end

        ACCESS: begin
          cnt     <= cnt - CNT_W'(1);
          err_acc <= err_acc | bus.mem_error;
          if (cnt == CNT_W'(1)) begin
            state      <= RESP;
            bus.mem_we <= 1'b0;
            if (owner == M_AUX) begin
              bus.m1_ack   <= 1'b1;
              bus.m1_rdata <= bus.mem_rdata;
              bus.m1_err   <= err_acc | bus.mem_error;
            end else begin
              bus.m0_ack   <= 1'b1;
              bus.m0_rdata <= bus.mem_rdata;
              bus.m0_err   <= err_acc | bus.mem_error;
            end
          end
        end

        RESP: begin
          state        <= IDLE;
          bus.m0_gnt   <= 1'b0;
          bus.m0_ack   <= 1'b0;
          bus.m0_rdata <= DATA_W'(0);
          bus.m0_err   <= 1'b0;
          bus.m1_gnt   <= 1'b0;
          bus.m1_ack   <= 1'b0;
          bus.m1_rdata <= DATA_W'(0);
          bus.m1_err   <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-timeline model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // stimulus for the current cycle
  logic        d_rst;
  logic        d_req   [2];
  logic        d_we    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic [31:0] d_rdata;
  logic        d_err;

  // model: one transaction at a time, described by its first grant cycle
  int          cyc;
  bit          busy;
  bit          own;
  bit          last;
  int          start;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, rcap;
  bit          err_or;
  bit          exp_ack [2];

  int n_pass, n_total;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
  endtask

  task automatic apply();
    rst           = d_rst;
    bus.m0_req    = d_req[0];
    bus.m0_we     = d_we[0];
    bus.m0_addr   = d_addr[0];
    bus.m0_wdata  = d_wdata[0];
    bus.m1_req    = d_req[1];
    bus.m1_we     = d_we[1];
    bus.m1_addr   = d_addr[1];
    bus.m1_wdata  = d_wdata[1];
    bus.mem_rdata = d_rdata;
    bus.mem_error = d_err;
  endtask

  // advance the model by the inputs driven in cycle cyc
  task automatic model_update();
    bit w;
    if (d_rst) begin
      busy = 0; last = 1; m_addr = '0; m_wdata = '0; m_we = 0;
    end else if (busy) begin
      if (cyc <= start + L - 1) begin
        err_or = err_or | d_err;
        if (cyc == start + L - 1) rcap = d_rdata;
      end
      if (cyc == start + L) busy = 0;
    end else if (d_req[0] || d_req[1]) begin
      if (d_req[0] && d_req[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w = ~last;
`else
        w = 1'b0;
`endif
      end else begin
        w = d_req[1];
      end
      busy = 1; own = w; last = w; start = cyc + 1;
      m_we = d_we[w]; m_addr = d_addr[w]; m_wdata = d_wdata[w]; err_or = 0;
    end
    cyc++;
  endtask

  // compare all DUT outputs with the model for the current cycle
  task automatic check_model();
    logic [31:0] gg [2], ga [2], gr [2], ge [2];
    bit g, a;
    gg[0] = 32'(bus.m0_gnt); ga[0] = 32'(bus.m0_ack); gr[0] = bus.m0_rdata; ge[0] = 32'(bus.m0_err);
    gg[1] = 32'(bus.m1_gnt); ga[1] = 32'(bus.m1_ack); gr[1] = bus.m1_rdata; ge[1] = 32'(bus.m1_err);
    for (int i = 0; i < 2; i++) begin
      g = busy && (own == i[0]);
      a = g && (cyc == start + L);
      exp_ack[i] = a;
      chk($sformatf("m%0d_gnt", i), gg[i], 32'(g));
      chk($sformatf("m%0d_ack", i), ga[i], 32'(a));
      if (!g) begin
        chk($sformatf("m%0d_rdata_idle", i), gr[i], 32'd0);
        chk($sformatf("m%0d_err_idle", i), ge[i], 32'd0);
      end else if (a) begin
        chk($sformatf("m%0d_err", i), ge[i], 32'(err_or));
        if (!m_we) chk($sformatf("m%0d_rdata", i), gr[i], rcap);
      end
    end
    chk("mem_we", 32'(bus.mem_we), 32'(busy && m_we && (cyc < start + L)));
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
  endtask

  task automatic start_cycle();
    @(negedge clk);
    check_model();
  endtask

  task automatic end_cycle();
    apply();
    model_update();
  endtask

  task automatic tick();
    start_cycle();
    end_cycle();
  endtask

  initial begin
    int got_n;
    int order [4];
    int exp_order;
    bit pend [2];

    n_pass = 0; n_total = 0; cyc = 0;
    busy = 0; own = 0; last = 1; start = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; rcap = '0; err_or = 0;
    d_rst = 1; d_rdata = '0; d_err = 0;
    for (int i = 0; i < 2; i++) begin
      d_req[i] = 0; d_we[i] = 0; d_addr[i] = '0; d_wdata[i] = '0;
      exp_ack[i] = 0; pend[i] = 0;
    end
    apply();

    // reset edge, outputs not yet defined
    @(negedge clk);
    end_cycle();
    d_rst = 0;

    // reset state
    start_cycle();
    chk("rst_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    end_cycle();

    // single read by m0
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h100; d_rdata = 32'hDEADBEEF;
    tick();
    start_cycle();
    chk("rd_gnt", 32'(bus.m0_gnt), 32'd1);
    chk("rd_addr", bus.mem_addr, 32'h100);
    chk("rd_we", 32'(bus.mem_we), 32'd0);
    end_cycle();
    start_cycle();
    chk("rd_addr2", bus.mem_addr, 32'h100);
    end_cycle();
    start_cycle();
    chk("rd_ack", 32'(bus.m0_ack), 32'd1);
    chk("rd_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("rd_err", 32'(bus.m0_err), 32'd0);
    chk("rd_m1_gnt", 32'(bus.m1_gnt), 32'd0);
    d_req[0] = 0;
    end_cycle();
    start_cycle();
    chk("rd_ack_gone", 32'(bus.m0_ack), 32'd0);
    end_cycle();

    // single write by m1
    d_req[1] = 1; d_we[1] = 1; d_addr[1] = 32'h200; d_wdata[1] = 32'h12345678;
    tick();
    for (int k = 0; k < 2; k++) begin
      start_cycle();
      chk("wr_we", 32'(bus.mem_we), 32'd1);
      chk("wr_addr", bus.mem_addr, 32'h200);
      chk("wr_wdata", bus.mem_wdata, 32'h12345678);
      end_cycle();
    end
    start_cycle();
    chk("wr_ack", 32'(bus.m1_ack), 32'd1);
    chk("wr_we_resp", 32'(bus.mem_we), 32'd0);
    d_req[1] = 0;
    end_cycle();
    tick();

    // error in first ACCESS cycle, then an error pulse while idle
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h700;
    tick();
    start_cycle(); d_err = 1; end_cycle();
    start_cycle(); d_err = 0; end_cycle();
    start_cycle();
    chk("err_ack", 32'(bus.m0_ack), 32'd1);
    chk("err_set", 32'(bus.m0_err), 32'd1);
    d_req[0] = 0;
    end_cycle();
    start_cycle(); d_err = 1; d_req[0] = 1; d_addr[0] = 32'h704; end_cycle();
    start_cycle(); d_err = 0; end_cycle();
    tick();
    start_cycle();
    chk("err_idle_ack", 32'(bus.m0_ack), 32'd1);
    chk("err_idle_clear", 32'(bus.m0_err), 32'd0);
    d_req[0] = 0;
    end_cycle();
    tick();

    // late arrival of m1 during m0's access
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h400;
    tick();
    start_cycle();
    chk("late_addr", bus.mem_addr, 32'h400);
    d_req[1] = 1; d_we[1] = 1; d_addr[1] = 32'h500; d_wdata[1] = 32'hA5A5A5A5;
    end_cycle();
    start_cycle();
    chk("late_addr2", bus.mem_addr, 32'h400);
    end_cycle();
    start_cycle();
    chk("late_m0_ack", 32'(bus.m0_ack), 32'd1);
    chk("late_m1_gnt_resp", 32'(bus.m1_gnt), 32'd0);
    d_req[0] = 0;
    end_cycle();
    start_cycle();
    chk("late_m1_gnt_idle", 32'(bus.m1_gnt), 32'd0);
    end_cycle();
    start_cycle();
    chk("late_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    chk("late_m1_addr", bus.mem_addr, 32'h500);
    end_cycle();
    tick();
    start_cycle();
    chk("late_m1_ack", 32'(bus.m1_ack), 32'd1);
    d_req[1] = 0;
    end_cycle();
    tick();

    // reset in the second ACCESS cycle, then a clean read
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h300; d_rdata = 32'hCAFEF00D;
    tick();
    tick();
    start_cycle(); d_rst = 1; d_req[0] = 0; end_cycle();
    start_cycle();
    chk("mrst_gnt", 32'(bus.m0_gnt), 32'd0);
    chk("mrst_ack", 32'(bus.m0_ack), 32'd0);
    chk("mrst_we", 32'(bus.mem_we), 32'd0);
    chk("mrst_addr", bus.mem_addr, 32'd0);
    d_rst = 0;
    end_cycle();
    start_cycle(); d_req[0] = 1; d_addr[0] = 32'h600; end_cycle();
    tick();
    tick();
    start_cycle();
    chk("mrst_new_ack", 32'(bus.m0_ack), 32'd1);
    chk("mrst_new_rdata", bus.m0_rdata, 32'hCAFEF00D);
    d_req[0] = 0;
    end_cycle();
    tick();

    // continuous contention from reset
    start_cycle(); d_rst = 1; end_cycle();
    d_rst = 0;
    d_req[0] = 1; d_req[1] = 1; d_we[0] = 0; d_we[1] = 0;
    d_addr[0] = 32'h1000; d_addr[1] = 32'h2000;
    got_n = 0;
    for (int k = 0; k < 4; k++) order[k] = 9;
    for (int k = 0; k < 40 && got_n < 4; k++) begin
      start_cycle();
      if (bus.m0_ack) begin order[got_n] = 0; got_n++; end
      else if (bus.m1_ack) begin order[got_n] = 1; got_n++; end
      end_cycle();
    end
    d_req[0] = 0; d_req[1] = 0;
    chk("cont_count", 32'(got_n), 32'd4);
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_order = k % 2;
`else
      exp_order = 0;
`endif
      chk($sformatf("cont_order%0d", k), 32'(order[k]), 32'(exp_order));
    end
    tick();

    // randomized traffic with occasional errors and resets
    for (int n = 0; n < 3000; n++) begin
      start_cycle();
      for (int i = 0; i < 2; i++) begin
        if (exp_ack[i]) pend[i] = 0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]     = 1;
          d_we[i]     = 1'($urandom_range(0, 1));
          d_addr[i]   = $urandom;
          d_wdata[i]  = $urandom;
        end
        d_req[i] = pend[i];
      end
      d_rdata = $urandom;
      d_err   = ($urandom_range(0, 7) == 0);
      d_rst   = ($urandom_range(0, 299) == 0);
      end_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the CPU's single-ported memory bus between the core (master 0) and a secondary master (master 1: program loader / debug port). One master owns the bus at a time. Each access is sequenced over a fixed memory latency, and a one-cycle acknowledge is returned with read data and error status. It sits between the core's memory port and the memory/peripheral decode.

## Interface
- `DATA_W`, 32: data width.
- `ADDR_W`, 32: address width.
- `MEM_LATENCY`, 2: number of cycles the address/we/wdata are held on the bus before read data is sampled; legal range 1–15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  request; held high with controls stable until the matching ack.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_W  byte address.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data.
- `m0_gnt`, `m1_gnt`  out  1  master owns the bus (ACCESS and RESP).
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data; valid only with ack.
- `m0_err`, `m1_err`  out  1  error status; valid only with ack.
- `mem_addr`  out  ADDR_W  bus address.
- `mem_wdata`  out  DATA_W  bus write data.
- `mem_we`  out  1  bus write strobe.
- `mem_rdata`  in  DATA_W  bus read data.
- `mem_error`  in  1  bus error.

## Operation
- States are IDLE, ACCESS and RESP.
- **IDLE**
  - Samples `m0_req` and `m1_req`.
  - If either is set: pick a winner, latch its addr/we/wdata into the bus registers, load the latency counter with `MEM_LATENCY`, clear the error accumulator, go to ACCESS.
  - If neither is set: stay in IDLE.
- **ACCESS**
  - `mem_addr`/`mem_wdata` are driven from the latched values; `mem_we` = latched we.
  - The counter decrements every cycle.
  - The error accumulator ORs in `mem_error` every cycle.
  - In the cycle the counter equals 1: capture `mem_rdata` into the response register, go to RESP.
- **RESP**
  - `mem_we` = 0.
  - The owner's ack = 1 for this cycle only, with rdata = captured value and err = accumulator.
  - For writes, rdata is don't-care.
  - Next state is IDLE.
- **Arbitration**
  - Only the winner sees gnt/ack. The loser's outputs stay 0 and its request stays pending.
  - The `last_winner` register is updated on every grant.
- **Outputs outside ownership:** gnt, ack, err and rdata are 0 when the master is not the owner.
- **Bus registers in IDLE:** `mem_addr`/`mem_wdata` hold their last latched value; `mem_we` = 0.
- **Request protocol:** a request still high when the arbiter re-enters IDLE (the cycle after ack) is treated as a new transaction. Masters drop req in the cycle after ack unless back-to-back access is intended.
- **Request withdrawal:** dropping req before ack is a protocol violation. The arbiter completes the access anyway and still pulses ack.
- **Reset values** (applied whenever `rst` = 1, including mid-ACCESS/RESP):
  - state = IDLE.
  - All gnt/ack/err/rdata = 0.
  - `mem_we` = 0; `mem_addr` = 0; `mem_wdata` = 0.
  - `last_winner` = 1, so master 0 wins the first contention.
  - An in-flight transaction is dropped; no ack is issued.

## Timing
- Request seen in IDLE at cycle T:
  - gnt from T+1 through T+1+MEM_LATENCY.
  - Bus held for cycles T+1 … T+MEM_LATENCY.
  - ack at T+1+MEM_LATENCY.
- Request-to-ack latency is MEM_LATENCY+1 cycles. With the default, req at T gives ack at T+3.
- Minimum back-to-back period is MEM_LATENCY+2 cycles (one IDLE cycle between accesses).
- `mem_rdata` is sampled on the clock edge closing the last ACCESS cycle. Memory must present data within MEM_LATENCY cycles of the address.
- A `mem_error` asserted during any ACCESS cycle is reported. A `mem_error` asserted during IDLE or RESP is ignored.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: when both requests are set in IDLE, grant the master that is not `last_winner`. This alternates 0,1,0,1 under continuous contention.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, master 0 always wins. `last_winner` is still maintained but not used for selection.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state encoding constants (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - master ID constants (M_CPU = 1'b0, M_AUX = 1'b1);
  - the latency counter width (4).
- One sub-module, `arb_pick`: combinational winner selection from (m0_req, m1_req, last_winner) to (valid, winner_id). The round-robin macro is applied inside it.
- The FSM, counter, bus registers and response registers live in `mem_arbiter`.

## Test plan
All scenarios use MEM_LATENCY = 2.
- **Single read:** m0 reads 0x100; memory returns 0xDEADBEEF → `mem_we` = 0 and `mem_addr` = 0x100 for 2 cycles; `m0_ack` 3 cycles after req with `m0_rdata` = 0xDEADBEEF and `m0_err` = 0; `m1_*` outputs stay 0.
- **Single write:** m1 writes 0x12345678 to 0x200 → `mem_we` = 1 for exactly 2 cycles with stable addr/wdata; one `m1_ack` pulse; `mem_we` = 0 in RESP.
- **Contention:** both masters hold req continuously for 4 transactions → with `MEM_ARB_ROUND_ROBIN_EN`, grant order is 0,1,0,1; without it, order is 0,0,0,0 and m1 is never granted.
- **Late arrival:** m1 raises req while m0 is in ACCESS → m1 gnt rises 2 cycles after `m0_ack` (RESP, then IDLE, then ACCESS); m0's access is not disturbed.
- **Error:** `mem_error` pulses for one cycle in the first ACCESS cycle of an m0 read → `m0_ack` with `m0_err` = 1. A `mem_error` pulse during IDLE → next ack has err = 0.
- **Mid-access reset:** `rst` asserted in the second ACCESS cycle → next cycle all outputs are 0 and `mem_we` = 0; no ack ever issued; after `rst` deasserts, a new m0 read completes normally with latency 3.
